ysyx_22040237_mem_arbiter: RTL
==============================

YSYX_22040237_MEM_ARBITER -- requirements
Module: ysyx_22040237_mem_arbiter

Interface
REQ-001 SHALL have parameters, one per line: ADDR_W, 64, address width / DATA_W, 64, data width / STARVE_LIMIT, 3, max consecutive LSU grants while IFU waits (1..7).
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-003 Ports, one per line (name direction width meaning):
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
halt_i  in  1  ebreak/invalid-inst halt; blocks new grants
ifu_req_valid  in  1  fetch request
ifu_req_addr  in  ADDR_W  fetch address
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_resp_valid  out  1  fetch data valid
ifu_resp_data  out  DATA_W  fetch data
lsu_req_valid  in  1  load/store request
lsu_req_we  in  1  1 = store
lsu_req_addr  in  ADDR_W  load/store address
lsu_req_wdata  in  DATA_W  store data
lsu_req_wstrb  in  DATA_W/8  store byte strobes
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_resp_valid  out  1  load data / store done
lsu_resp_data  out  DATA_W  load data
mem_req_valid  out  1  downstream request
mem_req_we  out  1  downstream write enable
mem_req_addr  out  ADDR_W  downstream address
mem_req_wdata  out  DATA_W  downstream write data
mem_req_wstrb  out  DATA_W/8  downstream strobes
mem_req_ready  in  1  downstream accepts request
mem_resp_valid  in  1  downstream response
mem_resp_data  in  DATA_W  downstream read data
busy_o  out  1  transaction in flight (state != IDLE)

Function
REQ-004 SHALL implement FSM IDLE, SEND, WAIT; exactly one outstanding transaction.
REQ-005 IDLE: if halt_i=0 and any *_req_valid, SHALL pick winner, assert its *_req_ready combinationally that cycle, register addr/we/wdata/wstrb/owner, go SEND; otherwise stay IDLE.
REQ-006 Arbitration: LSU priority over IFU, except IFU SHALL win when both valid and lsu_streak == STARVE_LIMIT.
REQ-007 lsu_streak (3-bit): +1, saturating at STARVE_LIMIT, on LSU grant while ifu_req_valid=1; cleared on IFU grant; unchanged otherwise.
REQ-008 IFU grant SHALL drive mem_req_we=0, mem_req_wstrb=0, mem_req_wdata=0.
REQ-009 SEND: mem_req_valid=1 with registered fields, held stable until mem_req_ready=1; then go WAIT.
REQ-010 WAIT: on mem_resp_valid=1 SHALL assert owner's *_resp_valid for that cycle only, with *_resp_data = mem_resp_data (combinational pass-through), go IDLE.
REQ-011 mem_resp_valid in IDLE or SEND SHALL be ignored; non-owner resp_valid SHALL stay 0.
REQ-012 Minimum latency: request accepted cycle N, mem_req_valid cycle N+1, response no earlier than N+2; next grant no earlier than cycle after response.
REQ-013 *_req_ready SHALL be 0 outside IDLE and whenever halt_i=1.
REQ-014 halt_i asserted in SEND/WAIT SHALL NOT abort transaction; completes and returns to IDLE, then grants nothing while halt_i=1.
REQ-015 mem_req_valid SHALL be 0 in IDLE and WAIT; resp data outputs SHALL be 0 when their resp_valid is 0.

Reset
REQ-016 On rst=1 at clock edge: state=IDLE, lsu_streak=0, registered request fields=0; all outputs 0 while state=IDLE and no request.
REQ-017 rst mid-transaction SHALL drop it without emitting any resp_valid; late mem_resp_valid after reset ignored per REQ-011.

Structure
REQ-018 FSM state encodings and owner encoding (IFU=0, LSU=1) SHALL live in the shared defines file.
REQ-019 One sub-module natural: ysyx_22040237_arb_pick (combinational winner select + streak update); rest flat.

Verification
REQ-020 Single IFU fetch addr 0x80000000, mem_req_ready=1, response 1 cycle later data 0x00100073 -> ifu_req_ready cycle 0, mem_req_valid cycle 1, ifu_resp_valid cycle 2 with 0x00100073, busy_o low cycle 3.
REQ-021 IFU and LSU valid same cycle, streak=0 -> LSU granted; store addr 0x80001000 wdata 0xDEADBEEF wstrb 0x0F seen on mem port; lsu_resp_valid only.
REQ-022 IFU and LSU continuously valid -> grant pattern LSU,LSU,LSU,IFU repeating with STARVE_LIMIT=3.
REQ-023 mem_req_ready low 4 cycles in SEND -> mem_req_* stable all 4 cycles; no ready to requesters; completes after.
REQ-024 halt_i raised in WAIT -> response delivered, then no grants with both requesters valid for 5 cycles; grants resume after halt_i falls.
REQ-025 rst pulsed in WAIT, mem_resp_valid next cycle -> no resp_valid on either side; state IDLE, streak 0.

Source files
------------

// File: rtl/ysyx_22040237_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states and
// request owner.
package ysyx_22040237_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam int STREAK_W = 3;

endpackage

// File: rtl/ysyx_22040237_arb_pick.sv
// Winner select between IFU and LSU. LSU has priority unless IFU has
// been starved for STARVE_LIMIT consecutive LSU grants.
module ysyx_22040237_arb_pick
   import ysyx_22040237_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 3
) (
   input  logic                en,
   input  logic                ifu_valid,
   input  logic                lsu_valid,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_ifu,
   output logic                grant_lsu,
   output logic [STREAK_W-1:0] streak_nxt
);

   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

   assign grant_ifu = en && ifu_valid && (!lsu_valid || streak == LIMIT);
   assign grant_lsu = en && lsu_valid && !grant_ifu;

   // Streak only counts LSU wins that actually kept a waiting IFU out.
   always_comb begin
      streak_nxt = streak;
      if (grant_ifu)
         streak_nxt = '0;
      else if (grant_lsu && ifu_valid && streak != LIMIT)
         streak_nxt = streak + STREAK_W'(1);
   end

endmodule

// File: rtl/ysyx_22040237_mem_arbiter.sv
// Single-outstanding memory arbiter: IFU and LSU share one downstream
// request/response port through an IDLE -> SEND -> WAIT sequence.
module ysyx_22040237_mem_arbiter
   import ysyx_22040237_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                halt_i,
   input  logic                ifu_req_valid,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_req_ready,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_resp_data,
   input  logic                lsu_req_valid,
   input  logic                lsu_req_we,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wstrb,
   output logic                lsu_req_ready,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_resp_data,
   output logic                mem_req_valid,
   output logic                mem_req_we,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wstrb,
   input  logic                mem_req_ready,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data,
   output logic                busy_o
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_e          state;
   owner_e              owner;
   logic [STREAK_W-1:0] streak, streak_nxt;
   logic                req_vld, req_we;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;
   logic [STRB_W-1:0]   req_wstrb;
   logic                grant_ifu, grant_lsu, resp_fire;

   ysyx_22040237_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .en         (state == ST_IDLE && !halt_i),
      .ifu_valid  (ifu_req_valid),
      .lsu_valid  (lsu_req_valid),
      .streak     (streak),
      .grant_ifu  (grant_ifu),
      .grant_lsu  (grant_lsu),
      .streak_nxt (streak_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner     <= OWN_IFU;
         streak    <= '0;
         req_vld   <= 1'b0;
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_wstrb <= '0;
      end else begin
         case (state)
            ST_IDLE: if (grant_ifu || grant_lsu) begin
               state     <= ST_SEND;
               req_vld   <= 1'b1;
               streak    <= streak_nxt;
               owner     <= grant_lsu ? OWN_LSU : OWN_IFU;
               // Fetches never write: strobes and data forced to zero.
               req_we    <= grant_lsu && lsu_req_we;
               req_addr  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
               req_wdata <= grant_lsu ? lsu_req_wdata : '0;
               req_wstrb <= grant_lsu ? lsu_req_wstrb : '0;
            end
            ST_SEND: if (mem_req_ready) begin
               state   <= ST_WAIT;
               req_vld <= 1'b0;
            end
            ST_WAIT: if (mem_resp_valid) state <= ST_IDLE;
            default: begin
               state   <= ST_IDLE;
               req_vld <= 1'b0;
            end
         endcase
      end
   end

   assign ifu_req_ready = grant_ifu;
   assign lsu_req_ready = grant_lsu;

   assign mem_req_valid = req_vld;
   assign mem_req_we    = req_vld && req_we;
   assign mem_req_addr  = req_vld ? req_addr  : '0;
   assign mem_req_wdata = req_vld ? req_wdata : '0;
   assign mem_req_wstrb = req_vld ? req_wstrb : '0;

   // Responses outside WAIT (stale or post-reset) are dropped here.
   assign resp_fire      = (state == ST_WAIT) && mem_resp_valid;
   assign ifu_resp_valid = resp_fire && owner == OWN_IFU;
   assign lsu_resp_valid = resp_fire && owner == OWN_LSU;
   assign ifu_resp_data  = ifu_resp_valid ? mem_resp_data : '0;
   assign lsu_resp_data  = lsu_resp_valid ? mem_resp_data : '0;

   assign busy_o = (state != ST_IDLE);

endmodule
